// File: rtl/prio_irq_pkg.sv
// ---------------------------------------------------------------------------
// prio_irq_pkg
// Shared definitions for the priority interrupt controller:
//   MODE_FIXED / MODE_RR - selection mode values for the MODE parameter
//   state_t              - offer state machine encoding
// ---------------------------------------------------------------------------
package prio_irq_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/prio_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// prio_irq_ctrl_if
// Offer handshake between the controller and the interrupt consumer.
//   req_valid : offer valid (controller -> consumer)
//   req_id    : offered source index, W bits (controller -> consumer)
//   req_ack   : consumer accepts the current offer (consumer -> controller)
// Handshake: an offer completes on a rising edge where req_valid and req_ack
// are both 1. While req_valid is 1, req_id is stable and the offer is never
// withdrawn. req_ack while req_valid is 0 has no effect.
// ---------------------------------------------------------------------------
interface prio_irq_ctrl_if #(
    parameter int N = 8
) ();
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic         req_valid;
    logic [W-1:0] req_id;
    logic         req_ack;

    modport master (output req_valid, output req_id, input req_ack);
    modport slave  (input req_valid, input req_id, output req_ack);
endinterface

// File: rtl/prio_enc_n.sv
// ---------------------------------------------------------------------------
// prio_enc_n
// Combinational N-input priority encoder with a movable starting point.
//   vec   [N-1:0] : candidate bits
//   start [W-1:0] : index checked first; scan proceeds downward with wrap
//   idx   [W-1:0] : first set bit found in scan order (0 when none)
//   found         : 1 when any bit of vec is set
// With start = N-1 this is a plain highest-index-wins encoder.
// ---------------------------------------------------------------------------
module prio_enc_n #(
    parameter int N = 8
) (
    input  logic [N-1:0]                        vec,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] start,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
    output logic                                found
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // The first hit in scan order wins; the found guard keeps later
        // (lower-priority) positions from overwriting it.
        for (int k = 0; k < N; k++) begin
            pos = start - W'(k);
            if (!found && vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// prio_irq_ctrl
// Registered priority interrupt controller. Request lines set sticky pending
// bits; unmasked pending bits are eligible; one eligible source at a time is
// offered on the bus handshake until acknowledged, which clears its bit.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ena          : allow a new selection (does not affect a live offer)
//   irq [N-1:0]  : request lines, a 1 sets the matching pending bit
//   mask_we/wd   : mask write strobe/data (1 = source masked)
//   bus          : offer handshake (req_valid, req_id, req_ack)
//   pend_any     : registered OR of pending & ~mask
//   pending_o    : pending register readback
//   mask_o       : mask register readback
//   state_o      : offer state machine state (debug)
//   last_o       : last granted index used by round-robin (debug)
// MODE: 0 = fixed priority (highest index), 1 = round-robin.
// ---------------------------------------------------------------------------
module prio_irq_ctrl
    import prio_irq_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic [N-1:0]                         irq,
    input  logic                                 mask_we,
    input  logic [N-1:0]                         mask_wd,
    prio_irq_ctrl_if.master                      bus,
    output logic                                 pend_any,
    output logic [N-1:0]                         pending_o,
    output logic [N-1:0]                         mask_o,
    output state_t                               state_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] last_o
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] mask_q, mask_d;
    logic [W-1:0] id_q, id_d;
    logic [W-1:0] last_q, last_d;
    logic         pend_any_q;

    logic [N-1:0] elig;
    logic [N-1:0] clr;
    logic [W-1:0] start;
    logic [W-1:0] sel;
    logic         sel_found;
    logic         accept;

    assign elig   = pending_q & ~mask_q;
    assign accept = (state_q == OFFER) && bus.req_ack;
    assign clr    = accept ? ({{(N-1){1'b0}}, 1'b1} << id_q) : '0;

    // Round-robin starts one below the last grant, so that grant becomes the
    // lowest priority; the W-bit subtraction wraps naturally.
    assign start = (MODE == MODE_RR) ? (last_q - 1'b1) : W'(N - 1);

    prio_enc_n #(.N(N)) u_enc (
        .vec   (elig),
        .start (start),
        .idx   (sel),
        .found (sel_found)
    );

    // A same-cycle irq re-sets a bit being cleared, so no event is lost.
    assign pending_d = (pending_q & ~clr) | irq;
    assign mask_d    = mask_we ? mask_wd : mask_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (ena && sel_found) begin
                    id_d    = sel;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.req_ack) begin
                    state_d = IDLE;
                    if (MODE == MODE_RR) begin
                        last_d = id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            id_q       <= '0;
            last_q     <= '0;
            pend_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            id_q       <= id_d;
            last_q     <= last_d;
            pend_any_q <= |(pending_d & ~mask_d);
        end
    end

    assign bus.req_valid = (state_q == OFFER);
    assign bus.req_id    = id_q;
    assign pend_any      = pend_any_q;
    assign pending_o     = pending_q;
    assign mask_o        = mask_q;
    assign state_o       = state_q;
    assign last_o        = last_q;
endmodule

// File: tb/tb_prio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prio_irq_ctrl
// Drives a fixed-priority and a round-robin controller (N=8) from shared
// request/mask stimulus with independent acks, and checks both every cycle
// against a behavioural model; directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_prio_irq_ctrl;
    import prio_irq_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wd;
    logic       ack0, ack1;

    logic       pa0, pa1;
    logic [7:0] pend0, pend1, mask0, mask1;
    state_t     st0, st1;
    logic [2:0] last0, last1;

    prio_irq_ctrl_if #(.N(8)) bus0 ();
    prio_irq_ctrl_if #(.N(8)) bus1 ();
    assign bus0.req_ack = ack0;
    assign bus1.req_ack = ack1;

    prio_irq_ctrl #(.N(8), .MODE(MODE_FIXED)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .irq(irq),
        .mask_we(mask_we), .mask_wd(mask_wd), .bus(bus0),
        .pend_any(pa0), .pending_o(pend0), .mask_o(mask0),
        .state_o(st0), .last_o(last0)
    );

    prio_irq_ctrl #(.N(8), .MODE(MODE_RR)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .irq(irq),
        .mask_we(mask_we), .mask_wd(mask_wd), .bus(bus1),
        .pend_any(pa1), .pending_o(pend1), .mask_o(mask1),
        .state_o(st1), .last_o(last1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_pend[2];
    logic [7:0] m_mask[2];
    logic       m_valid[2];
    logic [2:0] m_id[2];
    logic [2:0] m_last[2];
    logic       m_pa[2];
    bit         m_live = 0;

    // Scan positions by offset from the top of the search order.
    function automatic logic [3:0] pick(input logic [7:0] e, input bit rr, input logic [2:0] last);
        int i;
        for (int k = 1; k <= 8; k++) begin
            i = rr ? ((int'(last) - k + 8) % 8) : (8 - k);
            if (e[i]) return {1'b1, 3'(i)};
        end
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        logic       a;
        logic [7:0] elig;
        logic [7:0] clr;
        logic [3:0] p;
        for (int d = 0; d < 2; d++) begin
            a = (d == 1) ? ack1 : ack0;
            if (rst) begin
                m_pend[d]  = 8'h00;
                m_mask[d]  = 8'h00;
                m_valid[d] = 1'b0;
                m_id[d]    = 3'd0;
                m_last[d]  = 3'd0;
                m_pa[d]    = 1'b0;
            end else begin
                elig = m_pend[d] & ~m_mask[d];
                clr  = (m_valid[d] && a) ? (8'h01 << m_id[d]) : 8'h00;
                p    = pick(elig, d == 1, m_last[d]);
                if (m_valid[d]) begin
                    if (a) begin
                        m_valid[d] = 1'b0;
                        if (d == 1) m_last[d] = m_id[d];
                    end
                end else if (ena && p[3]) begin
                    m_valid[d] = 1'b1;
                    m_id[d]    = p[2:0];
                end
                m_pend[d] = (m_pend[d] & ~clr) | irq;
                if (mask_we) m_mask[d] = mask_wd;
                m_pa[d] = |(m_pend[d] & ~m_mask[d]);
            end
        end
        if (rst) m_live = 1;
    end

    task automatic cmp_dut(input string tag, input int d, input logic v, input logic [2:0] id,
                           input logic [7:0] pend, input logic [7:0] mask, input logic pa,
                           input logic [2:0] last, input state_t st);
        check({tag, " req_valid"}, 32'(v), 32'(m_valid[d]));
        check({tag, " req_id"}, 32'(id), 32'(m_id[d]));
        check({tag, " pending"}, 32'(pend), 32'(m_pend[d]));
        check({tag, " mask"}, 32'(mask), 32'(m_mask[d]));
        check({tag, " pend_any"}, 32'(pa), 32'(m_pa[d]));
        check({tag, " last"}, 32'(last), 32'(m_last[d]));
        check({tag, " state"}, 32'(st), m_valid[d] ? 32'(OFFER) : 32'(IDLE));
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp_dut("fixed", 0, bus0.req_valid, bus0.req_id, pend0, mask0, pa0, last0, st0);
            cmp_dut("rr", 1, bus1.req_valid, bus1.req_id, pend1, mask1, pa1, last1, st1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; irq = 8'h00; mask_we = 1'b0; mask_wd = 8'h00;
        ack0 = 1'b0; ack1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for an offer on the fixed-mode DUT and acknowledge it.
    task automatic take0(output logic [2:0] id, output bit ok);
        ok = 0;
        id = 3'd0;
        for (int c = 0; c < 8; c++) begin
            if (bus0.req_valid) begin
                id   = bus0.req_id;
                ok   = 1;
                ack0 = 1'b1;
                tick();
                ack0 = 1'b0;
                return;
            end
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] ids[6];
    logic [2:0] got;
    bit         ok;
    int         nofs, gap;
    logic [2:0] rr_exp[6];

    initial begin
        rst = 1'b1; ena = 1'b1; irq = 8'h00; mask_we = 1'b0; mask_wd = 8'h00;
        ack0 = 1'b0; ack1 = 1'b0;
        @(negedge clk);

        // Reset with all requests high, then release.
        irq = 8'hFF;
        tick(); tick();
        check("reset pending", 32'(pend0), 32'h00);
        check("reset valid", 32'(bus0.req_valid), 32'h0);
        check("reset pend_any", 32'(pa0), 32'h0);
        rst = 1'b0;
        tick();
        check("irq sets pending", 32'(pend0), 32'hFF);
        check("no offer same edge", 32'(bus0.req_valid), 32'h0);
        irq = 8'h00;
        tick();
        check("first offer valid", 32'(bus0.req_valid), 32'h1);
        check("first offer fixed id", 32'(bus0.req_id), 32'd7);
        check("first offer rr id", 32'(bus1.req_id), 32'd7);

        // Fixed priority: two pulses, ack each offer immediately.
        do_reset();
        irq = 8'b0010_0100;
        tick();
        irq = 8'h00;
        nofs = 0; gap = 0;
        for (int c = 0; c < 12; c++) begin
            ack0 = bus0.req_valid;
            if (bus0.req_valid) begin
                if (nofs < 2) ids[nofs] = bus0.req_id;
                nofs++;
            end else if (nofs == 1) begin
                gap++;
            end
            tick();
        end
        ack0 = 1'b0;
        check("fixed offer count", 32'(nofs), 32'd2);
        check("fixed first id", 32'(ids[0]), 32'd5);
        check("fixed second id", 32'(ids[1]), 32'd2);
        check("fixed idle gap", 32'(gap), 32'd1);
        check("fixed pending drained", 32'(pend0), 32'h00);

        // Round-robin with requests held.
        do_reset();
        irq = 8'b1000_0011;
        rr_exp[0] = 3'd7; rr_exp[1] = 3'd1; rr_exp[2] = 3'd0;
        rr_exp[3] = 3'd7; rr_exp[4] = 3'd1; rr_exp[5] = 3'd0;
        nofs = 0;
        for (int c = 0; c < 30 && nofs < 6; c++) begin
            ack1 = bus1.req_valid;
            if (bus1.req_valid) begin
                ids[nofs] = bus1.req_id;
                nofs++;
            end
            tick();
        end
        ack1 = 1'b0;
        irq  = 8'h00;
        check("rr offer count", 32'(nofs), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("rr seq[%0d]", i), 32'(ids[i]), 32'(rr_exp[i]));
        check("rr last after grants", 32'(last1), 32'd0);

        // Mask: masked source accumulates but is not offered until unmasked.
        do_reset();
        mask_we = 1'b1; mask_wd = 8'h80;
        tick();
        mask_we = 1'b0;
        irq = 8'h81;
        tick();
        irq = 8'h00;
        take0(got, ok);
        check("mask offer seen", 32'(ok), 32'h1);
        check("mask offer id", 32'(got), 32'd0);
        tick(); tick();
        check("masked not offered", 32'(bus0.req_valid), 32'h0);
        check("masked still pending", 32'(pend0), 32'h80);
        check("masked pend_any low", 32'(pa0), 32'h0);
        mask_we = 1'b1; mask_wd = 8'h00;
        tick();
        mask_we = 1'b0;
        take0(got, ok);
        check("unmask offer seen", 32'(ok), 32'h1);
        check("unmask offer id", 32'(got), 32'd7);
        check("unmask pending drained", 32'(pend0), 32'h00);

        // Hold and collision.
        do_reset();
        irq = 8'h08;
        tick();
        irq = 8'h00;
        for (int c = 0; c < 4 && !bus0.req_valid; c++) tick();
        check("hold offer id", 32'(bus0.req_id), 32'd3);
        for (int h = 0; h < 5; h++) begin
            irq     = (h == 1) ? 8'h40 : 8'h00;
            mask_we = (h == 2);
            mask_wd = 8'h08;
            tick();
            check("hold valid", 32'(bus0.req_valid), 32'h1);
            check("hold id", 32'(bus0.req_id), 32'd3);
        end
        mask_we = 1'b0;
        irq  = 8'h08;
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        irq  = 8'h00;
        check("collision set wins", 32'(pend0), 32'h48);
        check("valid drops after ack", 32'(bus0.req_valid), 32'h0);
        mask_we = 1'b1; mask_wd = 8'h00;
        tick();
        mask_we = 1'b0;
        take0(got, ok);
        check("after collision first id", 32'(got), 32'd6);
        take0(got, ok);
        check("re-offered id", 32'(got), 32'd3);
        check("re-offer seen", 32'(ok), 32'h1);

        // Reset in the middle of an offer.
        do_reset();
        irq = 8'h10; mask_we = 1'b1; mask_wd = 8'h01;
        tick();
        irq = 8'h00; mask_we = 1'b0;
        tick();
        check("mid offer valid", 32'(bus0.req_valid), 32'h1);
        check("mid offer id", 32'(bus0.req_id), 32'd4);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("rr last tracks grant", 32'(last1), 32'd4);
        irq = 8'h10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        irq = 8'h00;
        check("rst mid valid", 32'(bus0.req_valid), 32'h0);
        check("rst mid pending", 32'(pend0), 32'h00);
        check("rst mid mask", 32'(mask0), 32'h00);
        check("rst mid rr last", 32'(last1), 32'd0);
        check("rst mid state", 32'(st0), 32'(IDLE));

        // Randomized traffic, checked every cycle by the model compare.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            ena     = ($urandom_range(0, 3) != 0);
            irq     = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wd = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            ack0    = 1'($urandom_range(0, 1));
            ack1    = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; ack0 = 1'b0; ack1 = 1'b0; irq = 8'h00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
